cram_drain: RTL and testbench

Read-side controller for the byte-wide circular trace RAM. Tracks bytes committed by the multi-byte writer and drives the RAM's single-byte read port, absorbing its 1-cycle read latency. Presents the stored bytes in order as a valid/ready byte stream toward the trace transport (UART/stream packer). Reports fill level and free space back to the writer for flow control.

---
 rtl/cram_drain_pkg.sv | 14 +
 rtl/cram_drain_fifo.sv | 57 +++++
 rtl/cram_drain.sv | 103 ++++++++++
 tb/tb_cram_drain.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cram_drain_pkg.sv
// Shared sizing helpers and constants for the trace-RAM read-side controller.
package cram_drain_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_IW    = $clog2(FIFO_DEPTH);
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/cram_drain_fifo.sv
// Two-entry output buffer that absorbs RAM read latency; head is presented combinationally.
module cram_drain_fifo
  import cram_drain_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [W-1:0]       data_i,
  output logic [W-1:0]       data_o,
  output logic               valid_o,
  output logic [FIFO_CW-1:0] count_o
);
  logic [W-1:0]       mem_q [FIFO_DEPTH];
  logic [FIFO_IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [FIFO_CW-1:0] count_q, count_d;
  logic               do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q < FIFO_CW'(FIFO_DEPTH)) || do_pop);

  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_idx_d = wr_idx_q + 1'b1;
      if (do_pop)  rd_idx_d = rd_idx_q + 1'b1;
      count_d = count_q + FIFO_CW'(do_push) - FIFO_CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push && !flush_i) mem_q[wr_idx_q] <= data_i;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_idx_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
endmodule

// File: rtl/cram_drain.sv
// Read-side controller for the circular trace RAM: tracks committed bytes, issues
// single-byte reads and streams them out through a small buffer with valid/ready.
module cram_drain
  import cram_drain_pkg::*;
#(
  parameter int WORD_COUNT = 64,
  parameter int WORD_WIDTH = 8,
  parameter int IN_COUNT   = 16,
  localparam int PW = ptr_w(WORD_COUNT),
  localparam int CW = cnt_w(WORD_COUNT),
  localparam int IW = cnt_w(IN_COUNT)
) (
  input  logic                  io_clk,
  input  logic                  io_rstn,
  input  logic                  io_push_valid,
  input  logic [IW-1:0]         io_push_count,
  output logic [PW-1:0]         io_wr_addr,
  output logic [CW-1:0]         io_space,
  output logic [PW-1:0]         io_rd_addr,
  input  logic [WORD_WIDTH-1:0] io_rd_data,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [WORD_WIDTH-1:0] io_out_data,
  input  logic                  io_flush,
  output logic                  io_overflow
);
  // Stream handshake: a byte transfers on any cycle where io_out_valid && io_out_ready;
  // once valid is high, valid and data hold until that transfer happens.
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      pending_q, pending_d, space, push_cnt_ext;
  logic               inflight_q, inflight_d, overflow_q, overflow_d;
  logic [FIFO_CW-1:0] fifo_count;
  logic [2:0]         occupancy;
  logic               fifo_pop, fifo_push, credit, issue, push_ok;

  assign space        = CW'(WORD_COUNT) - pending_q;
  assign push_cnt_ext = CW'(io_push_count);
  assign fifo_pop     = io_out_valid && io_out_ready;
  // A read may only issue if its returning byte is guaranteed a buffer slot.
  assign occupancy    = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
  assign credit       = (occupancy < 3'(FIFO_DEPTH));
  assign fifo_push    = inflight_q && !io_flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pending_d  = pending_q;
    inflight_d = 1'b0;
    overflow_d = overflow_q;
    push_ok    = 1'b0;
    issue      = 1'b0;
    if (io_flush) begin
      rd_ptr_d   = wr_ptr_q;
      pending_d  = '0;
      overflow_d = 1'b0;
      if (io_push_valid && (push_cnt_ext <= CW'(WORD_COUNT))) begin
        wr_ptr_d  = wr_ptr_q + PW'(io_push_count);
        pending_d = push_cnt_ext;
      end
    end else begin
      push_ok    = io_push_valid && (push_cnt_ext <= space);
      issue      = (pending_q != '0) && credit;
      inflight_d = issue;
      if (io_push_valid && !push_ok) overflow_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(io_push_count);
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      pending_d = pending_q + (push_ok ? push_cnt_ext : '0) - CW'(issue);
    end
  end

  always_ff @(posedge io_clk or negedge io_rstn) begin
    if (!io_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pending_q  <= '0;
      inflight_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  cram_drain_fifo #(.W(WORD_WIDTH)) u_fifo (
    .clk     (io_clk),
    .rst_n   (io_rstn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (io_flush),
    .data_i  (io_rd_data),
    .data_o  (io_out_data),
    .valid_o (io_out_valid),
    .count_o (fifo_count)
  );

  assign io_wr_addr  = wr_ptr_q;
  assign io_rd_addr  = rd_ptr_q;
  assign io_space    = space;
  assign io_overflow = overflow_q;
endmodule

// File: tb/tb_cram_drain.sv
// Bench for cram_drain: RAM model, byte-order scoreboard, directed tables and random traffic.
module tb_cram_drain;
  localparam int WC = 64;

  logic       io_clk = 1'b0;
  logic       io_rstn = 1'b0;
  logic       io_push_valid = 1'b0;
  logic [4:0] io_push_count = '0;
  logic [5:0] io_wr_addr;
  logic [6:0] io_space;
  logic [5:0] io_rd_addr;
  logic [7:0] io_rd_data;
  logic       io_out_valid;
  logic       io_out_ready = 1'b0;
  logic [7:0] io_out_data;
  logic       io_flush = 1'b0;
  logic       io_overflow;

  cram_drain dut (
    .io_clk        (io_clk),
    .io_rstn       (io_rstn),
    .io_push_valid (io_push_valid),
    .io_push_count (io_push_count),
    .io_wr_addr    (io_wr_addr),
    .io_space      (io_space),
    .io_rd_addr    (io_rd_addr),
    .io_rd_data    (io_rd_data),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_data   (io_out_data),
    .io_flush      (io_flush),
    .io_overflow   (io_overflow)
  );

  // clock / reset / RAM model
  always #5 io_clk = ~io_clk;

  logic [7:0] mem [WC];
  always @(posedge io_clk) io_rd_data <= mem[io_rd_addr];

  int errors = 0;
  int checks = 0;
  int total_pushed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       use_rand = 1'b0;
  logic       clamp_push = 1'b0;
  logic [7:0] key = '0;

  typedef struct {
    logic       exp_valid;
    logic [7:0] exp_data;
  } out_vec_t;

  typedef struct {
    logic       pv;
    int         cnt;
    logic [6:0] exp_space;
    logic       exp_ov;
    logic [5:0] exp_wr;
  } fill_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge io_clk);
    io_rstn = 1'b0;
    io_push_valid = 1'b0;
    io_push_count = '0;
    io_out_ready = 1'b0;
    io_flush = 1'b0;
    repeat (2) @(negedge io_clk);
    io_rstn = 1'b1;
    exp_q.delete();
    got_q.delete();
    prev_stall = 1'b0;
    total_pushed = 0;
  endtask

  // One clock cycle of writer + consumer activity, observed mid-cycle.
  task automatic step(input logic pv, input int cnt, input logic rdy, input logic fl);
    int outstanding;
    logic [5:0] a;
    logic [7:0] b;
    @(negedge io_clk);
    if (clamp_push && cnt > int'(io_space)) cnt = int'(io_space);
    io_push_valid = pv;
    io_push_count = cnt[4:0];
    io_out_ready = rdy;
    io_flush = fl;
    #1;
    outstanding = WC - int'(io_space);
    chk("pending_bound", {31'd0, (outstanding <= exp_q.size()) && (outstanding + 2 >= exp_q.size())}, 32'd1);
    if (prev_stall) begin
      chk("stall_valid", {31'd0, io_out_valid}, 32'd1);
      chk("stall_data", {24'd0, io_out_data}, {24'd0, prev_data});
    end
    if (io_out_valid && rdy) begin
      got_q.push_back(io_out_data);
      if (exp_q.size() == 0) chk("unexpected_pop", {24'd0, io_out_data}, 32'hFFFF_FFFF);
      else chk("pop_data", {24'd0, io_out_data}, {24'd0, exp_q.pop_front()});
    end
    prev_stall = io_out_valid && !rdy && !fl;
    prev_data = io_out_data;
    if (fl) exp_q.delete();
    if (pv && (fl || cnt <= int'(io_space))) begin
      for (int i = 0; i < cnt; i++) begin
        a = io_wr_addr + 6'(i);
        b = use_rand ? 8'($urandom_range(0, 255)) : ({2'b00, a} ^ key);
        mem[a] = b;
        exp_q.push_back(b);
      end
      total_pushed += cnt;
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step(1'b0, 0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 0, 1'b1, 1'b0);
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    out_vec_t  ov[9];
    fill_vec_t fv[7];
    int c;
    logic pv;
    logic [7:0] e;

    for (int i = 0; i < WC; i++) mem[i] = '0;

    // ---- reset values (checked while reset is held) ----
    #3;
    chk("rst_valid", {31'd0, io_out_valid}, 32'd0);
    chk("rst_overflow", {31'd0, io_overflow}, 32'd0);
    chk("rst_space", {25'd0, io_space}, 32'd64);
    chk("rst_rd_addr", {26'd0, io_rd_addr}, 32'd0);
    chk("rst_wr_addr", {26'd0, io_wr_addr}, 32'd0);
    chk("rst_out_data", {24'd0, io_out_data}, 32'd0);

    // ---- latency table: push 5 at cycle 0, bytes on cycles 3..7 ----
    for (int k = 0; k < 9; k++) begin
      ov[k].exp_valid = (k >= 3 && k <= 7);
      ov[k].exp_data = (k >= 3 && k <= 7) ? 8'(8'h10 + k - 3) : 8'h00;
    end
    do_reset();
    use_rand = 1'b0;
    key = 8'h10;
    for (int k = 0; k < 9; k++) begin
      step(k == 0, (k == 0) ? 5 : 0, 1'b1, 1'b0);
      chk($sformatf("lat_valid_c%0d", k), {31'd0, io_out_valid}, {31'd0, ov[k].exp_valid});
      if (ov[k].exp_valid) chk($sformatf("lat_data_c%0d", k), {24'd0, io_out_data}, {24'd0, ov[k].exp_data});
      if (k == 1) chk("lat_space_c1", {25'd0, io_space}, 32'd59);
    end
    chk("lat_space_end", {25'd0, io_space}, 32'd64);
    chk("lat_count", got_q.size(), 32'd5);

    // ---- fill table with consumer stalled: two bytes are read ahead into the buffer ----
    fv[0] = '{1'b1, 16, 7'd48, 1'b0, 6'd16};
    fv[1] = '{1'b1, 16, 7'd33, 1'b0, 6'd32};
    fv[2] = '{1'b1, 16, 7'd18, 1'b0, 6'd48};
    fv[3] = '{1'b1, 16, 7'd2,  1'b0, 6'd0};
    fv[4] = '{1'b1, 2,  7'd0,  1'b0, 6'd2};
    fv[5] = '{1'b1, 1,  7'd0,  1'b1, 6'd2};
    fv[6] = '{1'b1, 0,  7'd0,  1'b1, 6'd2};
    do_reset();
    use_rand = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step(fv[k].pv, fv[k].cnt, 1'b0, 1'b0);
      @(posedge io_clk);
      #1;
      chk($sformatf("fill_space_%0d", k), {25'd0, io_space}, {25'd0, fv[k].exp_space});
      chk($sformatf("fill_ov_%0d", k), {31'd0, io_overflow}, {31'd0, fv[k].exp_ov});
      chk($sformatf("fill_wr_%0d", k), {26'd0, io_wr_addr}, {26'd0, fv[k].exp_wr});
    end
    drain(200);
    chk("fill_drained", got_q.size(), 32'd66);
    chk("fill_ov_sticky", {31'd0, io_overflow}, 32'd1);

    // ---- flush with 10 pending and 2 buffered, same-cycle push of 3 ----
    got_q.delete();
    step(1'b1, 12, 1'b0, 1'b0);
    repeat (4) step(1'b0, 0, 1'b0, 1'b0);
    chk("flush_pre_space", {25'd0, io_space}, 32'd54);
    chk("flush_pre_valid", {31'd0, io_out_valid}, 32'd1);
    step(1'b1, 3, 1'b0, 1'b1);
    @(posedge io_clk);
    #1;
    chk("flush_valid", {31'd0, io_out_valid}, 32'd0);
    chk("flush_ov", {31'd0, io_overflow}, 32'd0);
    chk("flush_space", {25'd0, io_space}, 32'd61);
    drain(30);
    chk("flush_count", got_q.size(), 32'd3);

    // ---- wrap: write pointer at 60, push 8 ----
    do_reset();
    use_rand = 1'b0;
    key = 8'h80;
    step(1'b1, 16, 1'b1, 1'b0);
    step(1'b1, 16, 1'b1, 1'b0);
    step(1'b1, 16, 1'b1, 1'b0);
    step(1'b1, 12, 1'b1, 1'b0);
    drain(100);
    chk("wrap_wr_addr", {26'd0, io_wr_addr}, 32'd60);
    chk("wrap_space", {25'd0, io_space}, 32'd64);
    got_q.delete();
    step(1'b1, 8, 1'b1, 1'b0);
    drain(40);
    chk("wrap_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      e = 8'((60 + i) % WC) ^ 8'h80;
      chk($sformatf("wrap_byte_%0d", i), (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, {24'd0, e});
    end

    // ---- random traffic, 1000 bytes, random ready ----
    do_reset();
    use_rand = 1'b1;
    clamp_push = 1'b1;
    for (int cyc = 0; cyc < 20000 && got_q.size() < 1000; cyc++) begin
      c = 0;
      pv = 1'b0;
      if (total_pushed < 1000 && $urandom_range(0, 1) == 1) begin
        pv = 1'b1;
        c = $urandom_range(0, ((1000 - total_pushed) < 16) ? (1000 - total_pushed) : 16);
      end
      step(pv, c, 1'($urandom_range(0, 1)), 1'b0);
    end
    clamp_push = 1'b0;
    chk("rand_count", got_q.size(), 32'd1000);
    chk("rand_pushed", total_pushed, 32'd1000);
    chk("rand_left", exp_q.size(), 32'd0);
    chk("rand_overflow", {31'd0, io_overflow}, 32'd0);

    // ---- asynchronous reset mid-drain ----
    do_reset();
    step(1'b1, 16, 1'b1, 1'b0);
    repeat (4) step(1'b0, 0, 1'b1, 1'b0);
    chk("arst_pre_valid", {31'd0, io_out_valid}, 32'd1);
    #2;
    io_rstn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, io_out_valid}, 32'd0);
    chk("arst_space", {25'd0, io_space}, 32'd64);
    chk("arst_rd_addr", {26'd0, io_rd_addr}, 32'd0);
    chk("arst_wr_addr", {26'd0, io_wr_addr}, 32'd0);
    chk("arst_out_data", {24'd0, io_out_data}, 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge io_clk);
    io_rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 0, 1'b1, 1'b0);
      chk($sformatf("arst_post_valid_%0d", k), {31'd0, io_out_valid}, 32'd0);
    end
    chk("arst_post_space", {25'd0, io_space}, 32'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
